// File: rtl/serial_bus_pkg.sv
// Shared types and elaboration-time helpers for the serial bus transmitter.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SRC   = 3'd2,
    ADDR  = 3'd3,
    DATA  = 3'd4,
    CRC   = 3'd5,
    STOP  = 3'd6
  } state_t;

  localparam logic [3:0] CRC_POLY_DEFAULT = 4'h3;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (32'sd1 <<< r) < value; r++) begin
    end
    return r;
  endfunction

  function automatic int frame_len(input int src_w, input int addr_w,
                                   input int data_w, input int crc_w);
    return 2 + src_w + addr_w + data_w + crc_w;
  endfunction

endpackage

// File: rtl/serial_bus_tx_crc.sv
// Serial LFSR CRC: one message bit per enabled cycle, zero-initialised on clear.
module crc_serial #(
  parameter int               CRC_W    = 4,
  parameter logic [CRC_W-1:0] CRC_POLY = 4'h3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_r;
  logic             fb_s;

  assign fb_s = bit_in ^ crc_r[CRC_W-1];

  // LFSR register: clear has priority over shifting in a new bit
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc_r <= {CRC_W{1'b0}};
    end else if (enable) begin
      crc_r <= {crc_r[CRC_W-2:0], 1'b0} ^ (fb_s ? CRC_POLY : {CRC_W{1'b0}});
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/serial_bus_tx.sv
// N-node round-robin arbitrated serial frame transmitter:
// start | src | addr | data | crc | stop, every field MSB first.
module serial_bus_tx
  import serial_bus_pkg::*;
#(
  parameter int               N_NODES  = 16,
  parameter int               DATA_W   = 64,
  parameter int               ADDR_W   = 4,
  parameter int               CRC_W    = 4,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEFAULT),
  parameter int               CRC_MODE = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_NODES-1:0]          mod,
  input  logic [N_NODES*DATA_W-1:0]   data_in,
  input  logic [N_NODES*ADDR_W-1:0]   addr_in,
  input  logic [N_NODES*CRC_W-1:0]    crc_in,
  output logic [N_NODES-1:0]          grant,
  output logic                        bus_out,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int SRC_W = clog2(N_NODES);
  localparam int PAY_W = SRC_W + ADDR_W + DATA_W;
  localparam int CNT_W = clog2(PAY_W + CRC_W) + 1;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [SRC_W-1:0]   ptr_r, ptr_s, win_s;
  logic [PAY_W-1:0]   shift_r, shift_s;
  logic [CRC_W-1:0]   crc_sh_r, crc_sh_s, crc_s;
  logic               bus_r, bus_s, busy_r, busy_s, done_r, done_s;
  logic [N_NODES-1:0] grant_r, grant_s, rot_s;
  logic [SRC_W:0]     shamt_s, off_s, sum_s;
  logic               crc_clr_s, crc_en_s;
  logic [CNT_W-1:0]   last_s;
  state_t             after_s;

  // Round-robin search: rotate {mod,mod} so the node after the pointer lands at bit 0
  always_comb begin
    shamt_s = {1'b0, ptr_r} + (SRC_W+1)'(1);
    rot_s   = N_NODES'({mod, mod} >> shamt_s);
    off_s   = {(SRC_W+1){1'b0}};
    for (int k = N_NODES-1; k >= 0; k--) begin
      off_s = rot_s[k] ? (SRC_W+1)'(k) : off_s;
    end
    sum_s = shamt_s + off_s;
    win_s = (sum_s >= (SRC_W+1)'(N_NODES)) ? SRC_W'(sum_s - (SRC_W+1)'(N_NODES))
                                            : SRC_W'(sum_s);
  end

  // Next-state logic; bus_s is the bit that appears on the line next cycle
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ptr_s     = ptr_r;
    shift_s   = shift_r;
    crc_sh_s  = crc_sh_r;
    bus_s     = 1'b0;
    busy_s    = busy_r;
    done_s    = 1'b0;
    grant_s   = {N_NODES{1'b0}};
    crc_clr_s = 1'b0;
    crc_en_s  = 1'b0;
    last_s    = (state_r == SRC) ? CNT_W'(SRC_W - 1) : CNT_W'(ADDR_W - 1);
    after_s   = (state_r == SRC) ? ADDR : DATA;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (|mod) begin
          state_s   = START;
          cnt_s     = {CNT_W{1'b0}};
          ptr_s     = win_s;
          grant_s   = {{(N_NODES-1){1'b0}}, 1'b1} << win_s;
          shift_s   = {win_s, addr_in[win_s*ADDR_W +: ADDR_W], data_in[win_s*DATA_W +: DATA_W]};
          crc_sh_s  = crc_in[win_s*CRC_W +: CRC_W];
          bus_s     = 1'b1;
          busy_s    = 1'b1;
          crc_clr_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s  = SRC;
        cnt_s    = {CNT_W{1'b0}};
        bus_s    = shift_r[PAY_W-1];
        shift_s  = shift_r << 1;
        crc_en_s = 1'b1;
      end
      SRC, ADDR: begin
        bus_s    = shift_r[PAY_W-1];
        shift_s  = shift_r << 1;
        crc_en_s = 1'b1;
        if (cnt_r == last_s) begin
          state_s = after_s;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == CNT_W'(DATA_W - 1)) begin
          // The LFSR has absorbed every payload bit by now
          state_s = CRC;
          cnt_s   = {CNT_W{1'b0}};
          if (CRC_MODE == 0) begin
            bus_s    = crc_s[CRC_W-1];
            crc_sh_s = crc_s << 1;
          end else begin
            bus_s    = crc_sh_r[CRC_W-1];
            crc_sh_s = crc_sh_r << 1;
          end
        end else begin
          cnt_s    = cnt_r + CNT_W'(1);
          bus_s    = shift_r[PAY_W-1];
          shift_s  = shift_r << 1;
          crc_en_s = 1'b1;
        end
      end
      CRC: begin
        if (cnt_r == CNT_W'(CRC_W - 1)) begin
          state_s = STOP;
          cnt_s   = {CNT_W{1'b0}};
          done_s  = 1'b1;
        end else begin
          cnt_s    = cnt_r + CNT_W'(1);
          bus_s    = crc_sh_r[CRC_W-1];
          crc_sh_s = crc_sh_r << 1;
        end
      end
      STOP: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      ptr_r    <= SRC_W'(N_NODES - 1);
      shift_r  <= {PAY_W{1'b0}};
      crc_sh_r <= {CRC_W{1'b0}};
      bus_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      grant_r  <= {N_NODES{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ptr_r    <= ptr_s;
      shift_r  <= shift_s;
      crc_sh_r <= crc_sh_s;
      bus_r    <= bus_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      grant_r  <= grant_s;
    end
  end

  crc_serial #(
    .CRC_W   (CRC_W),
    .CRC_POLY(CRC_POLY)
  ) u_crc (
    .clock (clock),
    .reset (reset),
    .clear (crc_clr_s),
    .enable(crc_en_s),
    .bit_in(shift_r[PAY_W-1]),
    .crc   (crc_s)
  );

  assign grant      = grant_r;
  assign bus_out    = bus_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_serial_bus_tx.sv
// Scoreboard bench: two DUTs (internal / external CRC) checked against a
// polynomial-division CRC and round-robin reference model.
module tb_serial_bus_tx;
  import serial_bus_pkg::*;

  localparam int N  = 16;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int SW = clog2(N);
  localparam int P  = SW + AW + DW;
  localparam int L  = frame_len(SW, AW, DW, CW);
  localparam logic [CW-1:0] POLY = 4'h3;

  typedef struct {
    int           node;
    logic [L-1:0] bits;
    int           nbits;
    bit           b2b;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N*DW-1:0] data_in;
  logic [N*AW-1:0] addr_in;
  logic [N*CW-1:0] crc_in;
  logic [N-1:0]    mod_v   [2];
  logic [N-1:0]    grant_w [2];
  logic [1:0]      bus_out_w, busy_w, done_w;

  exp_t exp_q [2][$];
  int   ptr_m [2];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int node);
    logic [N-1:0] v;
    v = '0;
    v[node] = 1'b1;
    return v;
  endfunction

  function automatic int next_winner(input int ptr, input logic [N-1:0] set);
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (ptr + i) % N;
      if (set[idx]) return idx;
    end
    return -1;
  endfunction

  // CRC as the remainder of msg * x^CW divided by x^CW + POLY
  function automatic logic [CW-1:0] crc_div(input logic [P-1:0] msg);
    logic [P+CW-1:0] v;
    logic [CW:0]     g;
    v = {msg, {CW{1'b0}}};
    g = {1'b1, POLY};
    for (int i = P + CW - 1; i >= CW; i--) begin
      if (v[i]) v[i -: CW+1] = v[i -: CW+1] ^ g;
    end
    return v[CW-1:0];
  endfunction

  function automatic exp_t build(input int m, input int node);
    exp_t          e;
    logic [P-1:0]  msg;
    logic [CW-1:0] c;
    msg = {SW'(node), addr_in[node*AW +: AW], data_in[node*DW +: DW]};
    c   = (m == 1) ? crc_in[node*CW +: CW] : crc_div(msg);
    e.node  = node;
    e.bits  = {1'b1, msg, c, 1'b0};
    e.nbits = L;
    e.b2b   = 1'b0;
    return e;
  endfunction

  genvar m;
  for (m = 0; m < 2; m++) begin : g_dut
    serial_bus_tx #(.CRC_MODE(m)) dut (
      .clock     (clock),
      .reset     (reset),
      .mod       (mod_v[m]),
      .data_in   (data_in),
      .addr_in   (addr_in),
      .crc_in    (crc_in),
      .grant     (grant_w[m]),
      .bus_out   (bus_out_w[m]),
      .busy      (busy_w[m]),
      .frame_done(done_w[m])
    );

    // Monitor: a grant marks bit 0 of a frame; collect it and compare with the queue head
    initial begin : mon
      exp_t         e;
      logic [L-1:0] act, dn, emask;
      logic         busy_ok;
      int           last_start;
      last_start = -1000;
      forever begin
        @(negedge clock);
        if (!reset && grant_w[m] != '0) begin
          if (exp_q[m].size() == 0) begin
            check("unexpected_grant", 128'(grant_w[m]), 128'(0));
          end else begin
            e = exp_q[m].pop_front();
            check("grant_onehot", 128'(grant_w[m]), 128'(onehot(e.node)));
            if (e.b2b) check("start_spacing", 128'(cyc - last_start), 128'(L + 1));
            last_start = cyc;
            act = '0; dn = '0; emask = '0; busy_ok = 1'b1;
            for (int k = 0; k < e.nbits; k++) begin
              if (k > 0) @(negedge clock);
              act[L-1-k]   = bus_out_w[m];
              dn[L-1-k]    = done_w[m];
              emask[L-1-k] = 1'b1;
              busy_ok      = busy_ok & busy_w[m];
            end
            check("frame_bits", 128'(act), 128'(e.bits & emask));
            check("frame_busy", 128'(busy_ok), 128'(1));
            if (e.nbits == L) begin
              check("frame_done_pos", 128'(dn), 128'(1));
              @(negedge clock);
              check("busy_drop", 128'(busy_w[m]), 128'(0));
            end else begin
              check("frame_done_pos", 128'(dn), 128'(0));
              @(negedge clock);
              check("reset_idle", 128'({bus_out_w[m], busy_w[m], done_w[m], grant_w[m]}), 128'(0));
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ptr_m[0] = N - 1;
    ptr_m[1] = N - 1;
  endtask

  task automatic wait_grant(input int mi, output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 2 * L + 4; i++) begin
      tick(1);
      lat++;
      if (grant_w[mi] != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_idle(input int mi);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * L + 4; i++) begin
      tick(1);
      if (!busy_w[mi]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 128'(0), 128'(1));
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      data_in[i*DW +: DW] = {$urandom, $urandom};
      addr_in[i*AW +: AW] = AW'($urandom);
      crc_in[i*CW +: CW]  = CW'($urandom);
    end
  endtask

  // Requesters in `set` each drop mod after their own grant
  task automatic serve(input int mi, input logic [N-1:0] set);
    logic [N-1:0] rem;
    int           cnt, w, lat;
    bit           ok;
    rem = set;
    cnt = 0;
    while (rem != '0) begin
      w = next_winner(ptr_m[mi], rem);
      exp_q[mi].push_back(build(mi, w));
      ptr_m[mi] = w;
      rem[w] = 1'b0;
      cnt++;
    end
    mod_v[mi] = set;
    for (int i = 0; i < cnt; i++) begin
      wait_grant(mi, ok, lat);
      if (!ok) break;
      if (i == 0) check("grant_latency", 128'(lat), 128'(1));
      mod_v[mi] = mod_v[mi] & ~grant_w[mi];
    end
    mod_v[mi] = '0;
    wait_idle(mi);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t         e;
    logic [N-1:0] set;
    int           w, lat;
    bit           ok;

    mod_v[0] = '0; mod_v[1] = '0;
    data_in = '0; addr_in = '0; crc_in = '0;
    reset = 1'b1;
    tick(3);
    check("reset_state", 128'({bus_out_w, busy_w, done_w}), 128'(0));
    check("reset_grant", 128'({grant_w[0], grant_w[1]}), 128'(0));
    reset = 1'b0;
    ptr_m[0] = N - 1;
    ptr_m[1] = N - 1;

    // All-zero payload from node 0, internal CRC
    serve(0, 16'h0001);

    // External CRC, node 1 with known fields
    data_in[1*DW +: DW] = 64'h1;
    addr_in[1*AW +: AW] = 4'h1;
    crc_in[1*CW +: CW]  = 4'h1;
    serve(1, 16'h0002);

    // Every node holds mod: 17 grants in round-robin order, start bits L+1 apart
    do_reset();
    randomize_inputs();
    for (int i = 0; i < 17; i++) begin
      w = next_winner(ptr_m[0], '1);
      e = build(0, w);
      e.b2b = (i > 0);
      exp_q[0].push_back(e);
      ptr_m[0] = w;
    end
    mod_v[0] = '1;
    for (int i = 0; i < 17; i++) begin
      wait_grant(0, ok, lat);
      if (!ok) break;
    end
    mod_v[0] = '0;
    wait_idle(0);

    // Node 3 changes its inputs right after grant; latched values must be sent
    randomize_inputs();
    w = next_winner(ptr_m[0], 16'h0008);
    exp_q[0].push_back(build(0, w));
    ptr_m[0] = w;
    mod_v[0] = 16'h0008;
    wait_grant(0, ok, lat);
    tick(1);
    data_in[3*DW +: DW] = ~data_in[3*DW +: DW];
    addr_in[3*AW +: AW] = ~addr_in[3*AW +: AW];
    mod_v[0] = '0;
    wait_idle(0);

    // Reset while bit 30 of a frame is on the line
    randomize_inputs();
    w = next_winner(ptr_m[0], 16'h0004);
    e = build(0, w);
    e.nbits = 31;
    exp_q[0].push_back(e);
    mod_v[0] = 16'h0004;
    wait_grant(0, ok, lat);
    mod_v[0] = '0;
    tick(30);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    ptr_m[0] = N - 1;
    ptr_m[1] = N - 1;
    serve(0, 16'h0021);

    // Random payloads and random request sets on both CRC modes
    for (int it = 0; it < 9; it++) begin
      randomize_inputs();
      set = '0;
      for (int j = 0; j < 3; j++) set[$urandom_range(N-1, 0)] = 1'b1;
      serve((it < 6) ? 0 : 1, set);
    end

    for (int i = 0; i < 200; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
      tick(1);
    end
    check("queue_drain", 128'(exp_q[0].size() + exp_q[1].size()), 128'(0));
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
